// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Sequencer for an iterative AES encryption round datapath. It accepts one
// plaintext/key pair per input handshake, loads the datapath (which performs
// the round-0 AddRoundKey), then issues one round command per round. The last
// round is flagged so that the datapath skips MixColumns. The final datapath
// state is captured as ciphertext and held on a valid/ready output.
//
// A per-wait watchdog aborts the block if the datapath does not answer within
// TIMEOUT cycles. The sticky error flag stays set until the next block is
// accepted.
//
// Ports:
//   i_clk, i_rst_n                  clock (rising edge), async active-low reset
//   i_in_valid / o_in_ready         plaintext/key handshake
//   i_in_block, i_in_key            plaintext and cipher key
//   o_out_valid / i_out_ready       ciphertext handshake
//   o_out_block                     ciphertext, registered
//   o_dp_load                       1-cycle pulse: datapath loads pt/key
//   o_dp_pt, o_dp_key               registered plaintext / key to datapath
//   o_dp_round_en                   1-cycle pulse: execute round o_dp_round_idx
//   o_dp_round_idx                  current round, 1..NR (0 before round 1)
//   o_dp_last                       with o_dp_round_en on the final round
//   i_dp_done, i_dp_state           datapath completion pulse and state
//   o_busy                          high whenever not idle
//   o_err                           sticky watchdog error
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int NR      = 10,
    parameter int DW      = 128,
    parameter int TIMEOUT = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_block,
    input  logic [DW-1:0] i_in_key,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_block,
    output logic          o_dp_load,
    output logic [DW-1:0] o_dp_pt,
    output logic [DW-1:0] o_dp_key,
    output logic          o_dp_round_en,
    output logic [3:0]    o_dp_round_idx,
    output logic          o_dp_last,
    input  logic          i_dp_done,
    input  logic [DW-1:0] i_dp_state,
    output logic          o_busy,
    output logic          o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_LOAD,
        S_ROUND,
        S_WAIT_RND,
        S_HOLD
    } state_t;

    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [3:0]     NR_IDX  = 4'(NR);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [DW-1:0]   r_out_block;
    logic            r_dp_load;
    logic [DW-1:0]   r_dp_pt;
    logic [DW-1:0]   r_dp_key;
    logic            r_dp_round_en;
    logic [3:0]      r_round_idx;
    logic            r_dp_last;
    logic            r_busy;
    logic            r_err;
    logic [WDW-1:0]  r_wdog;

    logic            w_wd_expire;
    logic [3:0]      w_idx_inc;

    // The watchdog value equals the number of wait cycles already spent, so
    // the TIMEOUT-th wait cycle is the one where it reads TIMEOUT-1.
    assign w_wd_expire = (r_wdog == WD_LAST);
    assign w_idx_inc   = r_round_idx + 4'd1;

    // The visible round index is only loaded when the first round command is
    // issued, so it reads 0 throughout IDLE/LOAD/WAIT_LOAD and then holds its
    // value between round pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_block   <= '0;
            r_dp_load     <= 1'b0;
            r_dp_pt       <= '0;
            r_dp_key      <= '0;
            r_dp_round_en <= 1'b0;
            r_round_idx   <= 4'd0;
            r_dp_last     <= 1'b0;
            r_busy        <= 1'b0;
            r_err         <= 1'b0;
            r_wdog        <= '0;
        end else begin
            // Command pulses last exactly one cycle unless re-armed below.
            r_dp_load     <= 1'b0;
            r_dp_round_en <= 1'b0;
            r_dp_last     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_in_valid && r_in_ready) begin
                        r_dp_pt    <= i_in_block;
                        r_dp_key   <= i_in_key;
                        r_err      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_dp_load  <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT_LOAD;
                end

                S_WAIT_LOAD: begin
                    // dp_done is checked first so it wins over a same-cycle expiry.
                    if (i_dp_done) begin
                        r_round_idx   <= 4'd1;
                        r_dp_round_en <= 1'b1;
                        r_dp_last     <= (NR_IDX == 4'd1);
                        r_state       <= S_ROUND;
                    end else if (w_wd_expire) begin
                        r_err       <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_round_idx <= 4'd0;
                        r_wdog      <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WDW'(1);
                    end
                end

                S_ROUND: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT_RND;
                end

                S_WAIT_RND: begin
                    if (i_dp_done) begin
                        if (r_round_idx == NR_IDX) begin
                            r_out_block <= i_dp_state;
                            r_out_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end else begin
                            r_round_idx   <= w_idx_inc;
                            r_dp_round_en <= 1'b1;
                            r_dp_last     <= (w_idx_inc == NR_IDX);
                            r_state       <= S_ROUND;
                        end
                    end else if (w_wd_expire) begin
                        r_err       <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_round_idx <= 4'd0;
                        r_wdog      <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + WDW'(1);
                    end
                end

                S_HOLD: begin
                    // No new block is taken in the handshake cycle; in_ready
                    // rises only once the controller is back in IDLE.
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_round_idx <= 4'd0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_round_idx <= 4'd0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready     = r_in_ready;
    assign o_out_valid    = r_out_valid;
    assign o_out_block    = r_out_block;
    assign o_dp_load      = r_dp_load;
    assign o_dp_pt        = r_dp_pt;
    assign o_dp_key       = r_dp_key;
    assign o_dp_round_en  = r_dp_round_en;
    assign o_dp_round_idx = r_round_idx;
    assign o_dp_last      = r_dp_last;
    assign o_busy         = r_busy;
    assign o_err          = r_err;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for aes_round_ctrl. A behavioural AES datapath model answers the
// controller's load/round commands with configurable latency; expected
// ciphertexts come from a software AES-128 encryption in the bench.
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         dp_load;
    logic [127:0] dp_pt;
    logic [127:0] dp_key;
    logic         dp_round_en;
    logic [3:0]   dp_round_idx;
    logic         dp_last;
    logic         dp_done;
    logic [127:0] dp_state;
    logic         busy;
    logic         err;

    aes_round_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_block     (in_block),
        .i_in_key       (in_key),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_block    (out_block),
        .o_dp_load      (dp_load),
        .o_dp_pt        (dp_pt),
        .o_dp_key       (dp_key),
        .o_dp_round_en  (dp_round_en),
        .o_dp_round_idx (dp_round_idx),
        .o_dp_last      (dp_last),
        .i_dp_done      (dp_done),
        .i_dp_state     (dp_state),
        .o_busy         (busy),
        .o_err          (err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // ---------------- software AES-128 ----------------
    logic [7:0] sbox_tbl [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_tbl[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                          ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        int r, c;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            r = i % 4;
            c = i / 4;
            o[127-8*i -: 8] = sbox_tbl[gb(s, r + 4*((c + r) % 4))];
        end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-32*c -: 8]  = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8]  = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] next_rk(input logic [127:0] rk, input int rnd);
        logic [7:0]  rc;
        logic [31:0] t, n0, n1, n2, n3;
        rc = 8'h01;
        for (int i = 1; i < rnd; i++) rc = xt(rc);
        t = {rk[23:0], rk[31:24]};
        t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        n0 = rk[127:96] ^ t;
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [127:0] o;
        o = sub_shift(s);
        if (!last) o = mix(o);
        return o ^ rk;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, rk;
        s  = pt ^ key;
        rk = key;
        for (int r = 1; r <= 10; r++) begin
            rk = next_rk(rk, r);
            s  = aes_round(s, rk, r == 10);
        end
        return s;
    endfunction

    // ---------------- datapath model + command log ----------------
    int           lat = 1;
    int           withhold_round = 0;
    int           pending = 0;
    int           last_cmd_idx = 0;
    logic [127:0] m_state = '0;
    logic [127:0] m_rk = '0;
    int           load_cnt = 0;
    int           load_cyc_q[$];
    int           ren_cyc_q[$];
    int           ren_idx_q[$];
    bit           last_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Commands are observed mid-cycle; a command seen in cycle C is answered
    // with dp_done during cycle C+lat.
    initial begin
        dp_done  = 1'b0;
        dp_state = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 0;
                dp_done = 1'b0;
            end else begin
                dp_done = 1'b0;
                if (pending > 0) begin
                    pending--;
                    if (pending == 0 && !(withhold_round != 0 && last_cmd_idx == withhold_round))
                        dp_done = 1'b1;
                end
                if (dp_load) begin
                    m_state = dp_pt ^ dp_key;
                    m_rk = dp_key;
                    pending = lat;
                    last_cmd_idx = 0;
                    load_cnt++;
                    load_cyc_q.push_back(cyc);
                end
                if (dp_round_en) begin
                    m_rk = next_rk(m_rk, int'(dp_round_idx));
                    m_state = aes_round(m_state, m_rk, dp_last);
                    pending = lat;
                    last_cmd_idx = int'(dp_round_idx);
                    ren_idx_q.push_back(int'(dp_round_idx));
                    last_q.push_back(dp_last);
                    ren_cyc_q.push_back(cyc);
                end
                dp_state = m_state;
            end
        end
    end

    task automatic clear_logs();
        load_cnt = 0;
        load_cyc_q.delete();
        ren_cyc_q.delete();
        ren_idx_q.delete();
        last_q.delete();
    endtask

    // Offers a block and returns at the cycle after acceptance; acc is the
    // cycle number in which the handshake happened.
    task automatic offer(input logic [127:0] pt, input logic [127:0] key, input int budget,
                         output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        @(negedge clk);
        in_block = pt;
        in_key   = key;
        in_valid = 1'b1;
        for (int n = 0; n < budget; n++) begin
            if (in_ready) begin
                acc = cyc;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int vc, output bit ok);
        ok = 1'b0;
        vc = -1;
        for (int n = 0; n < budget; n++) begin
            if (out_valid) begin
                vc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, busy, out_valid, dp_load, dp_round_en, dp_round_idx, dp_last, err} !== 11'b100_0000_0000)
            $display("FAIL reset_ctrl: got %b, expected %b",
                     {in_ready, busy, out_valid, dp_load, dp_round_en, dp_round_idx, dp_last, err}, 11'b100_0000_0000);
        else n_pass++;
        n_checks++;
        if ({out_block, dp_pt, dp_key} !== 384'h0)
            $display("FAIL reset_data: got %h %h %h, expected zeros", out_block, dp_pt, dp_key);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, busy} !== 2'b10)
            $display("FAIL reset_release: got in_ready/busy %b, expected 10", {in_ready, busy});
        else n_pass++;
    endtask

    task automatic test_fips();
        logic [127:0] key, pt, exp;
        int acc, vc;
        bit ok, seq_ok;
        key = 128'h000102030405060708090a0b0c0d0e0f;
        pt  = 128'h00112233445566778899aabbccddeeff;
        exp = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        lat = 1;
        withhold_round = 0;
        clear_logs();
        offer(pt, key, 20, acc, ok);
        n_checks++;
        if (!ok) $display("FAIL fips_accept: got no handshake, expected accept");
        else n_pass++;
        wait_out(100, vc, ok);
        n_checks++;
        if (!ok || vc !== acc + 23) $display("FAIL fips_latency: got cycle %0d, expected %0d", vc, acc + 23);
        else n_pass++;
        n_checks++;
        if (out_block !== exp) $display("FAIL fips_ct: got %h, expected %h", out_block, exp);
        else n_pass++;
        n_checks++;
        if (load_cnt !== 1 || load_cyc_q.size() == 0 || load_cyc_q[0] !== acc + 1)
            $display("FAIL fips_load: got %0d loads (first at %0d), expected 1 at %0d",
                     load_cnt, (load_cyc_q.size() > 0) ? load_cyc_q[0] : -1, acc + 1);
        else n_pass++;
        n_checks++;
        if (ren_cyc_q.size() == 0 || ren_cyc_q[0] !== acc + 3)
            $display("FAIL fips_first_round: got cycle %0d, expected %0d",
                     (ren_cyc_q.size() > 0) ? ren_cyc_q[0] : -1, acc + 3);
        else n_pass++;
        seq_ok = (ren_idx_q.size() == 10);
        for (int i = 0; i < ren_idx_q.size(); i++)
            if (ren_idx_q[i] != i + 1 || last_q[i] != (i == 9)) seq_ok = 1'b0;
        n_checks++;
        if (!seq_ok) $display("FAIL fips_round_seq: got %0d round pulses %p, expected idx 1..10 with last only on 10",
                              ren_idx_q.size(), ren_idx_q);
        else n_pass++;
        n_checks++;
        if (dp_pt !== pt || dp_key !== key)
            $display("FAIL fips_dp_regs: got pt %h key %h, expected pt %h key %h", dp_pt, dp_key, pt, key);
        else n_pass++;
        n_checks++;
        if ({busy, in_ready} !== 2'b10) $display("FAIL fips_hold_flags: got busy/in_ready %b, expected 10", {busy, in_ready});
        else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, busy, dp_round_idx} !== 7'b0100000)
            $display("FAIL fips_release: got %b, expected 0100000", {out_valid, in_ready, busy, dp_round_idx});
        else n_pass++;
        $display("fips: pt=%h key=%h ct=%h accept=%0d valid=%0d", pt, key, out_block, acc, vc);
    endtask

    task automatic test_hold_stall();
        logic [127:0] pt1, key1, exp1, pt2, key2, exp2;
        int acc, acc2, vc, bad;
        bit ok;
        pt1 = {$urandom, $urandom, $urandom, $urandom};
        key1 = {$urandom, $urandom, $urandom, $urandom};
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        key2 = {$urandom, $urandom, $urandom, $urandom};
        exp1 = aes_encrypt(pt1, key1);
        exp2 = aes_encrypt(pt2, key2);
        offer(pt1, key1, 20, acc, ok);
        wait_out(100, vc, ok);
        n_checks++;
        if (!ok || out_block !== exp1) $display("FAIL stall_ct1: got %h, expected %h", out_block, exp1);
        else n_pass++;
        // Offer a second block while the first is held unconsumed.
        in_block = pt2;
        in_key   = key2;
        in_valid = 1'b1;
        bad = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_block !== exp1 || in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL stall_hold: got %0d unstable cycles, expected 0", bad);
        else n_pass++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL stall_release: got out_valid/in_ready %b, expected 01", {out_valid, in_ready});
        else n_pass++;
        acc2 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(100, vc, ok);
        n_checks++;
        if (!ok || vc !== acc2 + 23 || out_block !== exp2)
            $display("FAIL stall_ct2: got %h at %0d, expected %h at %0d", out_block, vc, exp2, acc2 + 23);
        else n_pass++;
        $display("stall: ct1=%h ct2=%h", exp1, out_block);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_watchdog();
        logic [127:0] pt, key, exp;
        int acc, vc, ecyc, rcyc;
        bit ok, found, seen_ov;
        pt = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        lat = 1;
        withhold_round = 4;
        clear_logs();
        offer(pt, key, 20, acc, ok);
        found = 1'b0;
        seen_ov = 1'b0;
        ecyc = -1;
        for (int n = 0; n < 100; n++) begin
            if (out_valid) seen_ov = 1'b1;
            if (err) begin
                found = 1'b1;
                ecyc = cyc;
                break;
            end
            @(negedge clk);
        end
        rcyc = (ren_cyc_q.size() >= 4) ? ren_cyc_q[3] : -100;
        n_checks++;
        if (!found || ecyc !== rcyc + 17) $display("FAIL wd_err_time: got err at %0d, expected %0d", ecyc, rcyc + 17);
        else n_pass++;
        n_checks++;
        if ({busy, in_ready, out_valid, seen_ov} !== 4'b0100)
            $display("FAIL wd_idle: got busy/in_ready/out_valid/seen %b, expected 0100", {busy, in_ready, out_valid, seen_ov});
        else n_pass++;
        n_checks++;
        if (ren_idx_q.size() !== 4) $display("FAIL wd_rounds: got %0d rounds, expected 4", ren_idx_q.size());
        else n_pass++;
        withhold_round = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (err !== 1'b1) $display("FAIL wd_sticky: got err %b, expected 1", err);
        else n_pass++;
        $display("watchdog: err at cycle %0d", ecyc);
        pt = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        exp = aes_encrypt(pt, key);
        offer(pt, key, 20, acc, ok);
        n_checks++;
        if (err !== 1'b0) $display("FAIL wd_clear: got err %b, expected 0", err);
        else n_pass++;
        wait_out(100, vc, ok);
        n_checks++;
        if (!ok || out_block !== exp) $display("FAIL wd_recover_ct: got %h, expected %h", out_block, exp);
        else n_pass++;
        $display("watchdog recover: ct=%h", out_block);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt, key, exp;
        int acc, vc, bad;
        bit ok, found;
        pt = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        lat = 1;
        offer(pt, key, 20, acc, ok);
        found = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (dp_round_en && dp_round_idx == 4'd6) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!found) $display("FAIL rstmid_round6: got no round 6 pulse, expected one");
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, busy, out_valid, dp_load, dp_round_en, dp_round_idx, dp_last, err} !== 11'b100_0000_0000)
            $display("FAIL rstmid_ctrl: got %b, expected %b",
                     {in_ready, busy, out_valid, dp_load, dp_round_en, dp_round_idx, dp_last, err}, 11'b100_0000_0000);
        else n_pass++;
        n_checks++;
        if ({out_block, dp_pt, dp_key} !== 384'h0)
            $display("FAIL rstmid_data: got %h %h %h, expected zeros", out_block, dp_pt, dp_key);
        else n_pass++;
        bad = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (dp_load || dp_round_en || out_valid) bad++;
        end
        rst_n = 1'b1;
        n_checks++;
        if (bad != 0) $display("FAIL rstmid_quiet: got %0d active cycles in reset, expected 0", bad);
        else n_pass++;
        pt = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        exp = aes_encrypt(pt, key);
        offer(pt, key, 20, acc, ok);
        wait_out(100, vc, ok);
        n_checks++;
        if (!ok || vc !== acc + 23 || out_block !== exp)
            $display("FAIL rstmid_ct: got %h at %0d, expected %h at %0d", out_block, vc, exp, acc + 23);
        else n_pass++;
        $display("reset mid: ct=%h", out_block);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q[$];
        int got;
        lat = 3;
        withhold_round = 0;
        got = 0;
        fork
            begin : producer
                logic [127:0] pt, key;
                int acc;
                bit ok;
                for (int i = 0; i < 20; i++) begin
                    pt = {$urandom, $urandom, $urandom, $urandom};
                    key = {$urandom, $urandom, $urandom, $urandom};
                    offer(pt, key, 300, acc, ok);
                    n_checks++;
                    if (!ok) $display("FAIL b2b_accept: got no handshake for block %0d, expected accept", i);
                    else begin
                        n_pass++;
                        exp_q.push_back(aes_encrypt(pt, key));
                    end
                end
            end
            begin : consumer
                logic [127:0] e;
                for (int n = 0; n < 6000 && got < 20; n++) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        n_checks++;
                        if (exp_q.size() == 0)
                            $display("FAIL b2b_extra: got ct %h, expected none pending", out_block);
                        else begin
                            e = exp_q.pop_front();
                            if (out_block !== e) $display("FAIL b2b_ct: got %h, expected %h (block %0d)", out_block, e, got);
                            else n_pass++;
                        end
                        $display("b2b block %0d: ct=%h", got, out_block);
                        got++;
                    end
                end
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        n_checks++;
        if (got != 20 || exp_q.size() != 0)
            $display("FAIL b2b_count: got %0d outputs with %0d pending, expected 20 and 0", got, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        in_key    = '0;
        out_ready = 1'b0;
        init_sbox();
        test_reset();
        test_fips();
        test_hold_stall();
        test_watchdog();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no completion, expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
